// File: rtl/fc_classifier.sv
// rtl/fc_classifier.sv - final dense layer: image buffer, sequential MAC over weight ROM, argmax
//
// Purpose: collects NUM_IN pooled values from the last pooling stage, then for each
// class streams NUM_IN weights plus one bias from an external synchronous ROM through
// a two-stage pipe, emitting a saturated 12-bit score per class and the argmax digit.
//
// Ports:
//   cnn_clk       clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   pool_valid    pool_data valid this cycle
//   pool_data     signed 12-bit pooled value
//   weight_addr   ROM address: weight k*NUM_IN+i, bias NUM_CLASSES*NUM_IN+k
//   weight_data   signed 8-bit ROM word, valid one cycle after weight_addr
//   score_valid   one-cycle pulse, score/score_class valid
//   score_class   class index of score
//   score         signed saturated class score
//   result_valid  one-cycle pulse after the last class, digit valid
//   digit         argmax class
//   busy          high while computing
//   err_overrun   sticky, pool_valid seen while not collecting

module fc_classifier #(
    parameter int POOL_PER_MAP = 9,
    parameter int NUM_MAPS     = 12,
    parameter int NUM_IN       = NUM_MAPS * POOL_PER_MAP,
    parameter int NUM_CLASSES  = 10,
    parameter int ADDR_W       = 11
) (
    input  logic              cnn_clk,
    input  logic              rst_n,
    input  logic              pool_valid,
    input  logic [11:0]       pool_data,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [7:0]        weight_data,
    output logic              score_valid,
    output logic [3:0]        score_class,
    output logic [11:0]       score,
    output logic              result_valid,
    output logic [3:0]        digit,
    output logic              busy,
    output logic              err_overrun
);

    localparam int CNT_W = $clog2(NUM_IN);
    localparam int PH_W  = $clog2(NUM_IN + 4);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_IN - 1);
    localparam logic [PH_W-1:0]  PH_BIAS  = PH_W'(NUM_IN);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(NUM_IN + 3);
    localparam logic [3:0]       CLS_LAST = 4'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]   cnt;
    logic signed [11:0] in_buf [0:NUM_IN-1];

    logic [PH_W-1:0]    ph;
    logic [3:0]         cls;

    logic               s1_valid, s1_bias;
    logic [CNT_W-1:0]   s1_idx;
    logic               s2_valid, s2_bias;
    logic [CNT_W-1:0]   s2_idx;

    logic signed [31:0] acc;
    logic signed [11:0] best;
    logic [3:0]         best_idx;

    logic               collect_wr;
    logic               last_phase;
    logic signed [7:0]  wd;
    logic signed [19:0] prod;
    logic signed [31:0] mac_term;
    logic signed [31:0] shifted;
    logic signed [11:0] score_sat;

    assign collect_wr = (state == COLLECT) && pool_valid;
    assign last_phase = (state == RUN) && (ph == PH_LAST);
    assign busy       = (state == RUN);

    always_ff @(posedge cnn_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (collect_wr && (cnt == CNT_LAST)) state_nx = RUN;
            RUN:     if (last_phase && (cls == CLS_LAST)) state_nx = DONE;
            DONE:    state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    // The image buffer needs no reset: every entry is rewritten before it is read.
    always_ff @(posedge cnn_clk) begin
        if (collect_wr) begin
            in_buf[cnt] <= pool_data;
        end
    end

    // Multiply/accumulate operand select. The bias is pre-scaled by 2^7 so that it
    // lands on the same fixed-point grid as the input*weight products.
    always_comb begin
        wd       = weight_data;
        prod     = in_buf[s2_idx] * wd;
        mac_term = s2_bias ? {{17{wd[7]}}, wd, 7'd0} : {{12{prod[19]}}, prod};
        shifted  = acc >>> 7;
        if (shifted > 32'sd2047) begin
            score_sat = 12'sh7FF;
        end else if (shifted < -32'sd2048) begin
            score_sat = 12'sh800;
        end else begin
            score_sat = shifted[11:0];
        end
    end

    always_ff @(posedge cnn_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            ph           <= '0;
            cls          <= '0;
            s1_valid     <= 1'b0;
            s1_bias      <= 1'b0;
            s1_idx       <= '0;
            s2_valid     <= 1'b0;
            s2_bias      <= 1'b0;
            s2_idx       <= '0;
            acc          <= '0;
            best         <= '0;
            best_idx     <= '0;
            weight_addr  <= '0;
            score_valid  <= 1'b0;
            score_class  <= '0;
            score        <= '0;
            result_valid <= 1'b0;
            digit        <= '0;
            err_overrun  <= 1'b0;
        end else begin
            score_valid  <= 1'b0;
            result_valid <= 1'b0;

            if (pool_valid && (state != COLLECT)) begin
                err_overrun <= 1'b1;
            end

            // ROM read stage: the registered address is seen by the ROM one cycle
            // later, so its data arrives while s2 describes it.
            s2_valid <= s1_valid;
            s2_bias  <= s1_bias;
            s2_idx   <= s1_idx;

            case (state)
                COLLECT: begin
                    ph       <= '0;
                    cls      <= '0;
                    acc      <= '0;
                    s1_valid <= 1'b0;
                    s1_bias  <= 1'b0;
                    if (collect_wr) begin
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                    end
                end

                RUN: begin
                    ph <= last_phase ? '0 : ph + 1'b1;

                    if (ph < PH_BIAS) begin
                        weight_addr <= ADDR_W'(cls * NUM_IN + ph);
                        s1_valid    <= 1'b1;
                        s1_bias     <= 1'b0;
                        s1_idx      <= ph[CNT_W-1:0];
                    end else if (ph == PH_BIAS) begin
                        weight_addr <= ADDR_W'(NUM_CLASSES * NUM_IN + cls);
                        s1_valid    <= 1'b1;
                        s1_bias     <= 1'b1;
                    end else begin
                        s1_valid    <= 1'b0;
                        s1_bias     <= 1'b0;
                    end

                    // The pipe is drained by the last phase, so clearing acc there
                    // never collides with a pending accumulate.
                    if (last_phase) begin
                        acc         <= '0;
                        cls         <= cls + 1'b1;
                        score       <= score_sat;
                        score_class <= cls;
                        score_valid <= 1'b1;
                        if ((cls == 4'd0) || (score_sat > best)) begin
                            best     <= score_sat;
                            best_idx <= cls;
                        end
                    end else if (s2_valid) begin
                        acc <= acc + mac_term;
                    end
                end

                DONE: begin
                    cnt          <= '0;
                    s1_valid     <= 1'b0;
                    s1_bias      <= 1'b0;
                    result_valid <= 1'b1;
                    digit        <= best_idx;
                end

                default: begin
                    s1_valid <= 1'b0;
                    s1_bias  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_classifier.sv
// tb/tb_fc_classifier.sv - directed self-checking bench for fc_classifier

module tb_fc_classifier;

    logic        cnn_clk = 1'b0;
    logic        rst_n;
    logic        pool_valid;
    logic [11:0] pool_data;
    logic [10:0] weight_addr;
    logic [7:0]  weight_data;
    logic        score_valid;
    logic [3:0]  score_class;
    logic [11:0] score;
    logic        result_valid;
    logic [3:0]  digit;
    logic        busy;
    logic        err_overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  rom [0:2047];
    logic [11:0] exp_sc [0:9];

    int          n_sv;
    logic [11:0] sv_val [0:15];
    logic [3:0]  sv_cls [0:15];
    int          sv_cyc [0:15];
    int          n_rv;
    int          rv_cyc;
    logic [3:0]  rv_digit;
    int          busy_seen;
    int          acc_edge;

    fc_classifier dut (
        .cnn_clk      (cnn_clk),
        .rst_n        (rst_n),
        .pool_valid   (pool_valid),
        .pool_data    (pool_data),
        .weight_addr  (weight_addr),
        .weight_data  (weight_data),
        .score_valid  (score_valid),
        .score_class  (score_class),
        .score        (score),
        .result_valid (result_valid),
        .digit        (digit),
        .busy         (busy),
        .err_overrun  (err_overrun)
    );

    always #5 cnn_clk = ~cnn_clk;

    always @(posedge cnn_clk) begin
        cyc         <= cyc + 1;
        weight_data <= rom[weight_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // mode 1: class-3 weights 7F; 2: class-0 weights 7F; 3: all weights 7F; 4: bias7 = 5
    task automatic set_rom(input int mode);
        for (int a = 0; a < 2048; a++) rom[a] = 8'h00;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 108; i++) begin
                if ((mode == 1 && k == 3) || (mode == 2 && k == 0) || mode == 3)
                    rom[k * 108 + i] = 8'h7F;
            end
        end
        if (mode == 4) rom[1080 + 7] = 8'h05;
    endtask

    task automatic feed(input logic [11:0] v);
        for (int i = 0; i < 108; i++) begin
            @(negedge cnn_clk);
            pool_valid = 1'b1;
            pool_data  = v;
        end
        @(negedge cnn_clk);
        pool_valid = 1'b0;
        acc_edge   = cyc;
    endtask

    task automatic observe(input int inject_at, input int reset_at);
        n_sv      = 0;
        n_rv      = 0;
        rv_cyc    = 0;
        rv_digit  = 4'h0;
        busy_seen = 0;
        for (int c = 1; c <= 1200; c++) begin
            @(negedge cnn_clk);
            if (score_valid && n_sv < 16) begin
                sv_val[n_sv] = score;
                sv_cls[n_sv] = score_class;
                sv_cyc[n_sv] = cyc;
                n_sv++;
            end
            if (result_valid) begin
                n_rv++;
                rv_cyc   = cyc;
                rv_digit = digit;
            end
            if (busy) busy_seen = 1;
            pool_valid = 1'b0;
            if (c == inject_at) begin
                pool_valid = 1'b1;
                pool_data  = 12'h555;
            end
            if (c == reset_at) rst_n = 1'b0;
            if (c == reset_at + 2) rst_n = 1'b1;
        end
    endtask

    task automatic check_scores(input string tn, input logic [3:0] exp_digit);
        check({tn, " score count"}, n_sv, 10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s class idx %0d", tn, k), sv_cls[k], k);
            check($sformatf("%s score %0d", tn, k), sv_val[k], exp_sc[k]);
        end
        check({tn, " result pulses"}, n_rv, 1);
        check({tn, " digit"}, rv_digit, exp_digit);
    endtask

    initial begin
        rst_n      = 1'b0;
        pool_valid = 1'b0;
        pool_data  = 12'h000;
        set_rom(0);
        repeat (3) @(negedge cnn_clk);
        check("reset busy", busy, 0);
        check("reset score_valid", score_valid, 0);
        check("reset result_valid", result_valid, 0);
        check("reset weight_addr", weight_addr, 0);
        check("reset score", score, 0);
        check("reset digit", digit, 0);
        check("reset err_overrun", err_overrun, 0);
        rst_n = 1'b1;
        @(negedge cnn_clk);

        // 1: unit inputs, class 3 weights 127 -> 108*127 >>> 7 = 107
        set_rom(1);
        for (int k = 0; k < 10; k++) exp_sc[k] = 12'h000;
        exp_sc[3] = 12'h06B;
        feed(12'h001);
        observe(0, 0);
        check_scores("t1", 4'd3);
        check("t1 busy seen", busy_seen, 1);
        check("t1 busy after", busy, 0);
        check("t1 addr hold", weight_addr, 11'd1089);
        check("t1 err", err_overrun, 0);

        // 2: inputs -1, class 0 weights 127 -> floor(-13716/128) = -108
        set_rom(2);
        for (int k = 0; k < 10; k++) exp_sc[k] = 12'h000;
        exp_sc[0] = 12'hF94;
        feed(12'hFFF);
        observe(0, 0);
        check_scores("t2", 4'd1);

        // 3: saturation on every class, ties keep class 0
        set_rom(3);
        for (int k = 0; k < 10; k++) exp_sc[k] = 12'h7FF;
        feed(12'h7FF);
        observe(0, 0);
        check_scores("t3", 4'd0);

        // 4: bias-only class 7, plus score/result timing
        set_rom(4);
        for (int k = 0; k < 10; k++) exp_sc[k] = 12'h000;
        exp_sc[7] = 12'h005;
        feed(12'h123);
        observe(0, 0);
        check_scores("t4", 4'd7);
        for (int k = 0; k < 10; k++)
            check($sformatf("t4 sv timing %0d", k), sv_cyc[k] - acc_edge, (k + 1) * 112);
        check("t4 rv timing", rv_cyc - acc_edge, 1121);
        check("t4 score hold", score, 12'h000);

        // 5: overrun during RUN, computation unaffected
        set_rom(1);
        for (int k = 0; k < 10; k++) exp_sc[k] = 12'h000;
        exp_sc[3] = 12'h06B;
        feed(12'h001);
        observe(50, 0);
        check_scores("t5", 4'd3);
        check("t5 err", err_overrun, 1);

        // 6: reset mid-RUN aborts with no result, then a fresh image works
        feed(12'h001);
        observe(0, 300);
        check("t6 abort result pulses", n_rv, 0);
        check("t6 abort busy", busy, 0);
        check("t6 abort err cleared", err_overrun, 0);
        check("t6 abort digit", digit, 0);
        set_rom(4);
        for (int k = 0; k < 10; k++) exp_sc[k] = 12'h000;
        exp_sc[7] = 12'h005;
        feed(12'h7FF);
        observe(0, 0);
        check_scores("t6", 4'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
